// File: rtl/uplus_100g_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the CMAC TX AXI-Stream port.
// Gates new grants on link status and truncates packets longer than MAX_BEATS.
module uplus_100g_tx_arbiter #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned KEEP_W    = 64,
  parameter int unsigned MAX_BEATS = 150
) (
  input  logic                        i_tx_clk,
  input  logic                        i_sys_rst_n,
  input  logic                        i_link_ok,
  input  logic [NUM_SRC-1:0]          i_s_tvalid,
  output logic [NUM_SRC-1:0]          o_s_tready,
  input  logic [NUM_SRC*DATA_W-1:0]   i_s_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0]   i_s_tkeep,
  input  logic [NUM_SRC-1:0]          i_s_tlast,
  input  logic [NUM_SRC-1:0]          i_s_tuser,
  output logic                        o_m_tvalid,
  input  logic                        i_m_tready,
  output logic [DATA_W-1:0]           o_m_tdata,
  output logic [KEEP_W-1:0]           o_m_tkeep,
  output logic                        o_m_tlast,
  output logic                        o_m_tuser,
  output logic [NUM_SRC-1:0]          o_grant,
  output logic [15:0]                 o_abort_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);
  localparam int unsigned POS_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(MAX_BEATS);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StDrop = 2'd2
  } state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [NUM_SRC-1:0]   r_grant;
  logic [IDX_W-1:0]     r_last_grant;
  logic [CNT_W-1:0]     r_beat_cnt;
  logic [15:0]          r_abort_cnt;

  logic [IDX_W-1:0]     w_sel_idx;
  logic                 w_any_req;
  logic                 w_src_valid;
  logic                 w_src_last;
  logic                 w_src_user;
  logic [DATA_W-1:0]    w_src_data;
  logic [KEEP_W-1:0]    w_src_keep;
  logic                 w_at_limit;
  logic                 w_trunc;
  logic                 w_accept;
  logic                 w_drop_acc;

  // r_last_grant doubles as the current owner index while in XFER/DROP.
  assign w_src_valid = i_s_tvalid[r_last_grant];
  assign w_src_last  = i_s_tlast[r_last_grant];
  assign w_src_user  = i_s_tuser[r_last_grant];
  assign w_src_data  = i_s_tdata[r_last_grant*DATA_W +: DATA_W];
  assign w_src_keep  = i_s_tkeep[r_last_grant*KEEP_W +: KEEP_W];

  assign w_any_req  = |i_s_tvalid;
  assign w_at_limit = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign w_trunc    = w_at_limit & ~w_src_last;
  assign w_accept   = (r_state == StXfer) & w_src_valid & i_m_tready;
  assign w_drop_acc = (r_state == StDrop) & w_src_valid;

  // Scan downwards so the nearest requester after last_grant is written last.
  always_comb begin
    logic [POS_W-1:0] v_pos;
    v_pos     = '0;
    w_sel_idx = r_last_grant;
    for (int i = int'(NUM_SRC); i >= 1; i--) begin
      v_pos = {1'b0, r_last_grant} + POS_W'(i);
      if (v_pos >= POS_W'(NUM_SRC)) begin
        v_pos = v_pos - POS_W'(NUM_SRC);
      end
      if (i_s_tvalid[v_pos[IDX_W-1:0]]) begin
        w_sel_idx = v_pos[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge i_tx_clk) begin
    if (!i_sys_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_link_ok && w_any_req) begin
          w_state_next = StXfer;
        end
      end
      StXfer: begin
        if (w_accept) begin
          if (w_src_last) begin
            w_state_next = StIdle;
          end else if (w_at_limit) begin
            w_state_next = StDrop;
          end
        end
      end
      StDrop: begin
        if (w_drop_acc && w_src_last) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_tx_clk) begin
    if (!i_sys_rst_n) begin
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_SRC - 1);
      r_beat_cnt   <= '0;
      r_abort_cnt  <= '0;
    end else begin
      if (r_state == StIdle && w_state_next == StXfer) begin
        r_grant      <= NUM_SRC'(1) << w_sel_idx;
        r_last_grant <= w_sel_idx;
        r_beat_cnt   <= '0;
      end else if (w_state_next == StIdle) begin
        r_grant <= '0;
      end
      // Only count beats that keep the packet in XFER so the counter never wraps.
      if (w_accept && w_state_next == StXfer) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_accept && w_trunc && r_abort_cnt != 16'hFFFF) begin
        r_abort_cnt <= r_abort_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    o_m_tvalid = 1'b0;
    o_m_tdata  = '0;
    o_m_tkeep  = '0;
    o_m_tlast  = 1'b0;
    o_m_tuser  = 1'b0;
    o_s_tready = '0;
    unique case (r_state)
      StXfer: begin
        o_m_tvalid = w_src_valid;
        o_m_tdata  = w_src_data;
        o_m_tkeep  = w_src_keep;
        o_m_tlast  = w_src_last | w_trunc;
        o_m_tuser  = w_src_user | w_trunc;
        o_s_tready = r_grant & {NUM_SRC{i_m_tready}};
      end
      StDrop: begin
        o_s_tready = r_grant;
      end
      default: ;
    endcase
  end

  assign o_grant     = r_grant;
  assign o_abort_cnt = r_abort_cnt;

endmodule

// File: tb/tb_uplus_100g_tx_arbiter.sv
// Directed bench for uplus_100g_tx_arbiter: fairness, link gate, backpressure,
// truncation (second instance with MAX_BEATS = 4) and mid-packet reset.
module tb_uplus_100g_tx_arbiter;

  localparam int NS = 4;
  localparam int DW = 64;
  localparam int KW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               link_ok;
  logic               m_tready;
  logic [NS-1:0]      s_tvalid;
  logic [NS-1:0]      s_tlast;
  logic [NS-1:0]      s_tuser;
  logic [NS*DW-1:0]   s_tdata;
  logic [NS*KW-1:0]   s_tkeep;

  logic [NS-1:0] a_s_tready, t_s_tready;
  logic          a_m_tvalid, t_m_tvalid;
  logic [DW-1:0] a_m_tdata,  t_m_tdata;
  logic [KW-1:0] a_m_tkeep,  t_m_tkeep;
  logic          a_m_tlast,  t_m_tlast;
  logic          a_m_tuser,  t_m_tuser;
  logic [NS-1:0] a_grant,    t_grant;
  logic [15:0]   a_abort,    t_abort;

  uplus_100g_tx_arbiter #(
    .NUM_SRC(NS), .DATA_W(DW), .KEEP_W(KW), .MAX_BEATS(8)
  ) u_dut (
    .i_tx_clk(clk), .i_sys_rst_n(rst_n), .i_link_ok(link_ok),
    .i_s_tvalid(s_tvalid), .o_s_tready(a_s_tready), .i_s_tdata(s_tdata),
    .i_s_tkeep(s_tkeep), .i_s_tlast(s_tlast), .i_s_tuser(s_tuser),
    .o_m_tvalid(a_m_tvalid), .i_m_tready(m_tready), .o_m_tdata(a_m_tdata),
    .o_m_tkeep(a_m_tkeep), .o_m_tlast(a_m_tlast), .o_m_tuser(a_m_tuser),
    .o_grant(a_grant), .o_abort_cnt(a_abort)
  );

  uplus_100g_tx_arbiter #(
    .NUM_SRC(NS), .DATA_W(DW), .KEEP_W(KW), .MAX_BEATS(4)
  ) u_dut_t (
    .i_tx_clk(clk), .i_sys_rst_n(rst_n), .i_link_ok(link_ok),
    .i_s_tvalid(s_tvalid), .o_s_tready(t_s_tready), .i_s_tdata(s_tdata),
    .i_s_tkeep(s_tkeep), .i_s_tlast(s_tlast), .i_s_tuser(s_tuser),
    .o_m_tvalid(t_m_tvalid), .i_m_tready(m_tready), .o_m_tdata(t_m_tdata),
    .o_m_tkeep(t_m_tkeep), .o_m_tlast(t_m_tlast), .o_m_tuser(t_m_tuser),
    .o_grant(t_grant), .o_abort_cnt(t_abort)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Source model: each source sends src_len-beat packets while src_on is set.
  bit            src_on   [NS];
  bit            src_once [NS];
  int            src_len  [NS];
  int            src_beat [NS];
  int            src_pkt  [NS];
  bit            use_t;
  logic [NS-1:0] hs;

  function automatic logic [DW-1:0] pat(int k, int p, int b);
    return {8'hC0 | 8'(k), 8'(p), 8'(b), 40'h5A3C960FE1};
  endfunction

  function automatic logic [KW-1:0] kpat(int b, int len);
    return (b == len - 1) ? 8'h0F : 8'hFF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NS; k++) begin
      s_tvalid[k]           = src_on[k];
      s_tlast[k]            = src_on[k] && (src_beat[k] == src_len[k] - 1);
      s_tuser[k]            = 1'b0;
      s_tdata[k*DW +: DW]   = src_on[k] ? pat(k, src_pkt[k], src_beat[k]) : '0;
      s_tkeep[k*KW +: KW]   = src_on[k] ? kpat(src_beat[k], src_len[k]) : '0;
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < NS; k++) begin
      src_on[k] = 0; src_once[k] = 0; src_len[k] = 1; src_beat[k] = 0; src_pkt[k] = 0;
    end
    drive();
  endtask

  task automatic start(input int k, input int len, input bit once);
    src_on[k] = 1; src_len[k] = len; src_once[k] = once; src_beat[k] = 0;
    drive();
  endtask

  // Called at the negedge after checks: records handshakes, advances one cycle.
  task automatic tick();
    hs = s_tvalid & (use_t ? t_s_tready : a_s_tready);
    @(posedge clk);
    #1;
    for (int k = 0; k < NS; k++) begin
      if (hs[k]) begin
        src_beat[k]++;
        if (src_beat[k] == src_len[k]) begin
          src_beat[k] = 0;
          src_pkt[k]++;
          if (src_once[k]) src_on[k] = 0;
        end
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", a_grant, 0);
    chk("rst_tvalid", a_m_tvalid, 0);
    chk("rst_tdata", a_m_tdata, 0);
    chk("rst_tready", a_s_tready, 0);
    chk("rst_abort_a", a_abort, 0);
    chk("rst_abort_t", t_abort, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int owner, phase, pkt, exp_beat, c;
    bit tr_pat [4];
    tr_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0; link_ok = 1'b1; m_tready = 1'b1; use_t = 1'b0;
    reset_model();

    // 1. Fairness: four continuous 3-beat sources, grants rotate 0,1,2,3,0.
    do_reset();
    for (int k = 0; k < NS; k++) start(k, 3, 0);
    for (int cy = 0; cy < 20; cy++) begin
      phase = cy % 4; owner = (cy / 4) % 4; pkt = cy / 16;
      @(negedge clk);
      if (phase == 0) begin
        chk("fair_idle_grant", a_grant, 0);
        chk("fair_idle_tvalid", a_m_tvalid, 0);
        chk("fair_idle_tready", a_s_tready, 0);
      end else begin
        chk("fair_grant", a_grant, 64'(1) << owner);
        chk("fair_tready", a_s_tready, 64'(1) << owner);
        chk("fair_tvalid", a_m_tvalid, 1);
        chk("fair_tdata", a_m_tdata, pat(owner, pkt, phase - 1));
        chk("fair_tkeep", a_m_tkeep, kpat(phase - 1, 3));
        chk("fair_tlast", a_m_tlast, (phase == 3) ? 1 : 0);
      end
      tick();
    end

    // 2. Link gate: no grant while link down; link drop mid-packet is ignored.
    link_ok = 1'b0;
    do_reset();
    start(2, 3, 1);
    for (int cy = 0; cy < 20; cy++) begin
      @(negedge clk);
      chk("gate_grant", a_grant, 0);
      chk("gate_tready", a_s_tready, 0);
      tick();
    end
    link_ok = 1'b1;
    @(negedge clk);
    chk("gate_rise_grant", a_grant, 0);
    tick();
    @(negedge clk);
    chk("gate_grant2", a_grant, 4'b0100);
    chk("gate_b0", a_m_tdata, pat(2, 0, 0));
    tick();
    link_ok = 1'b0;
    @(negedge clk);
    chk("gate_b1_valid", a_m_tvalid, 1);
    chk("gate_b1", a_m_tdata, pat(2, 0, 1));
    tick();
    @(negedge clk);
    chk("gate_b2", a_m_tdata, pat(2, 0, 2));
    chk("gate_b2_last", a_m_tlast, 1);
    chk("gate_b2_grant", a_grant, 4'b0100);
    tick();
    @(negedge clk);
    chk("gate_end_grant", a_grant, 0);
    chk("gate_end_valid", a_m_tvalid, 0);
    tick();
    link_ok = 1'b1;

    // 3. Backpressure on a 5-beat packet from source 3.
    do_reset();
    start(3, 5, 1);
    @(negedge clk);
    chk("bp_idle_grant", a_grant, 0);
    tick();
    exp_beat = 0; c = 0;
    while (exp_beat < 5 && c < 20) begin
      m_tready = tr_pat[c % 4];
      @(negedge clk);
      chk("bp_tready", a_s_tready, m_tready ? 4'b1000 : 4'b0000);
      chk("bp_tvalid", a_m_tvalid, 1);
      chk("bp_tdata", a_m_tdata, pat(3, 0, exp_beat));
      chk("bp_tkeep", a_m_tkeep, kpat(exp_beat, 5));
      chk("bp_tlast", a_m_tlast, (exp_beat == 4) ? 1 : 0);
      tick();
      if (m_tready) exp_beat++;
      c++;
    end
    chk("bp_cycles", c, 9);
    m_tready = 1'b1;
    @(negedge clk);
    chk("bp_end_grant", a_grant, 0);
    tick();

    // 4. Truncation on the MAX_BEATS = 4 instance.
    use_t = 1'b1;
    do_reset();
    start(1, 7, 1);
    @(negedge clk);
    chk("tr_idle_grant", t_grant, 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("tr_grant", t_grant, 4'b0010);
      chk("tr_tvalid", t_m_tvalid, 1);
      chk("tr_tdata", t_m_tdata, pat(1, 0, b));
      chk("tr_tlast", t_m_tlast, (b == 3) ? 1 : 0);
      chk("tr_tuser", t_m_tuser, (b == 3) ? 1 : 0);
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      chk("drop_tvalid", t_m_tvalid, 0);
      chk("drop_tready", t_s_tready, 4'b0010);
      chk("drop_grant", t_grant, 4'b0010);
      chk("drop_tdata", t_m_tdata, 0);
      chk("drop_abort", t_abort, 1);
      tick();
    end
    @(negedge clk);
    chk("drop_end_grant", t_grant, 0);
    chk("drop_end_abort", t_abort, 1);
    tick();
    start(1, 4, 1);
    @(negedge clk);
    chk("ex4_idle_grant", t_grant, 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("ex4_tvalid", t_m_tvalid, 1);
      chk("ex4_tdata", t_m_tdata, pat(1, 1, b));
      chk("ex4_tlast", t_m_tlast, (b == 3) ? 1 : 0);
      chk("ex4_tuser", t_m_tuser, 0);
      tick();
    end
    @(negedge clk);
    chk("ex4_end_grant", t_grant, 0);
    chk("ex4_abort", t_abort, 1);
    tick();

    // 5. Reset during the second beat of a packet.
    use_t = 1'b0;
    do_reset();
    start(2, 4, 1);
    @(negedge clk);
    chk("mr_idle_grant", a_grant, 0);
    tick();
    @(negedge clk);
    chk("mr_b0", a_m_tdata, pat(2, 0, 0));
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_b1", a_m_tdata, pat(2, 0, 1));
    tick();
    reset_model();
    @(negedge clk);
    chk("mr_grant", a_grant, 0);
    chk("mr_tvalid", a_m_tvalid, 0);
    chk("mr_tready", a_s_tready, 0);
    chk("mr_abort_a", a_abort, 0);
    chk("mr_abort_t", t_abort, 0);
    tick();
    rst_n = 1'b1;
    start(0, 2, 1);
    start(3, 2, 1);
    @(negedge clk);
    chk("mr_rel_idle", a_grant, 0);
    tick();
    @(negedge clk);
    chk("mr_first_grant", a_grant, 4'b0001);
    chk("mr_first_data", a_m_tdata, pat(0, 0, 0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
